// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EXE-stage multiply/divide sequencing controller.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2,
    DONE     = 2'd3
  } muldiv_state_e;

  localparam logic [1:0]  OPK_NONE = 2'd0;
  localparam logic [1:0]  OPK_MUL  = 2'd1;
  localparam logic [1:0]  OPK_DIV  = 2'd2;

  localparam logic [31:0] DIV0_LO  = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_cnt.sv
// Shared cycle counter: loads on accept, counts down for the multiplier latency
// and up for the divider watchdog, and flags the terminal counts.
module muldiv_cnt #(
  parameter int CNT_W = 6,
  parameter int TERM  = 39
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one,
  output logic             is_term
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_one  = (cnt == CNT_W'(1));
  assign is_term = (cnt == CNT_W'(TERM));

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencing controller for the EXE stage.
// Optional build macro MULDIV_DIV0_FAST_EN: divide-by-zero bypasses the divider.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT     = 2,
  parameter int DIV_MAX_CYC = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic [1:0]  op_kind_i,
  input  logic        signed_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  input  logic        flush_i,
  input  logic        pipe_stall_i,
  output logic        mul_start_o,
  output logic        div_start_o,
  output logic        div_cancel_o,
  output logic        unit_signed_o,
  output logic [31:0] unit_opa_o,
  output logic [31:0] unit_opb_o,
  input  logic [63:0] mul_result_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        stall_o,
  output logic        result_valid_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        err_o
);

  localparam int CNT_MAX = (MUL_LAT > DIV_MAX_CYC) ? MUL_LAT : DIV_MAX_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  muldiv_state_e    state, state_nxt;
  logic             is_mul, is_div, div0_fast, acc;
  logic             mul_done, div_done, div_tmo;
  logic [CNT_W-1:0] cnt;
  logic             cnt_is_one, cnt_is_term;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    case (op_kind_i)
      OPK_MUL:  is_mul = 1'b1;
      OPK_DIV:  is_div = 1'b1;
      OPK_NONE: ;
      default:  ;
    endcase
  end

`ifdef MULDIV_DIV0_FAST_EN
  assign div0_fast = is_div & (opb_i == '0);
`else
  assign div0_fast = 1'b0;
`endif

  assign acc      = (state == IDLE) & op_valid_i & (is_mul | is_div) & ~flush_i;
  assign mul_done = (state == MUL_BUSY) & cnt_is_one;
  assign div_done = (state == DIV_BUSY) & div_ready_i;
  // Watchdog fires in the cycle the counter would reach DIV_MAX_CYC.
  assign div_tmo  = (state == DIV_BUSY) & ~div_ready_i & cnt_is_term;

  muldiv_cnt #(
    .CNT_W (CNT_W),
    .TERM  (DIV_MAX_CYC - 1)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (acc),
    .load_val (is_mul ? CNT_W'(MUL_LAT) : '0),
    .inc      (state == DIV_BUSY),
    .dec      (state == MUL_BUSY),
    .cnt      (cnt),
    .is_one   (cnt_is_one),
    .is_term  (cnt_is_term)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (acc) begin
          if (is_mul)         state_nxt = MUL_BUSY;
          else if (div0_fast) state_nxt = DONE;
          else                state_nxt = DIV_BUSY;
        end
      end
      MUL_BUSY: if (mul_done) state_nxt = DONE;
      DIV_BUSY: if (div_done | div_tmo) state_nxt = DONE;
      DONE:     if (!pipe_stall_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_comb begin
    stall_o        = acc | (state == MUL_BUSY) | (state == DIV_BUSY);
    result_valid_o = (state == DONE);
  end

  // Start/cancel pulses and operand/result registers; a flush never updates hi/lo.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_start_o   <= 1'b0;
      div_start_o   <= 1'b0;
      div_cancel_o  <= 1'b0;
      unit_signed_o <= 1'b0;
      unit_opa_o    <= '0;
      unit_opb_o    <= '0;
      hi_o          <= '0;
      lo_o          <= '0;
      err_o         <= 1'b0;
    end else begin
      mul_start_o  <= acc & is_mul;
      div_start_o  <= acc & is_div & ~div0_fast;
      div_cancel_o <= (state == DIV_BUSY) & (flush_i | div_tmo);
      if (acc) begin
        unit_signed_o <= signed_i;
        unit_opa_o    <= opa_i;
        unit_opb_o    <= opb_i;
      end
      if (acc & div0_fast) begin
        {hi_o, lo_o} <= {opa_i, DIV0_LO};
      end else if (!flush_i) begin
        if (mul_done) begin
          {hi_o, lo_o} <= mul_result_i;
        end else if (div_done) begin
          {hi_o, lo_o} <= div_result_i;
        end else if (div_tmo) begin
          {hi_o, lo_o} <= '0;
          err_o        <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with small multiplier/divider models.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_i, signed_i, flush_i, pipe_stall_i;
  logic [1:0]  op_kind_i;
  logic [31:0] opa_i, opb_i;
  logic        mul_start_o, div_start_o, div_cancel_o, unit_signed_o;
  logic [31:0] unit_opa_o, unit_opb_o;
  logic [63:0] mul_result_i, div_result_i;
  logic        div_ready_i;
  logic        stall_o, result_valid_o, err_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(2), .DIV_MAX_CYC(40)) dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_kind_i(op_kind_i),
    .signed_i(signed_i), .opa_i(opa_i), .opb_i(opb_i), .flush_i(flush_i),
    .pipe_stall_i(pipe_stall_i), .mul_start_o(mul_start_o), .div_start_o(div_start_o),
    .div_cancel_o(div_cancel_o), .unit_signed_o(unit_signed_o), .unit_opa_o(unit_opa_o),
    .unit_opb_o(unit_opb_o), .mul_result_i(mul_result_i), .div_ready_i(div_ready_i),
    .div_result_i(div_result_i), .stall_o(stall_o), .result_valid_o(result_valid_o),
    .hi_o(hi_o), .lo_o(lo_o), .err_o(err_o)
  );

  // Multiplier model: product valid only in the cycle after the start pulse is seen.
  function automatic logic [63:0] prod(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  logic        mv = 1'b0;
  logic [63:0] mp = '0;
  always @(posedge clk) begin
    mv <= mul_start_o;
    mp <= prod(unit_signed_o, unit_opa_o, unit_opb_o);
  end
  assign mul_result_i = mv ? mp : 64'hBAD0_BAD0_BAD0_BAD0;

  // Divider model: ready for one cycle dlat cycles after the start pulse; dlat=0 never answers.
  function automatic logic [63:0] divm(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  int          dlat = 0;
  int          dcnt = 0;
  logic        dbusy = 1'b0;
  logic [63:0] dres = '0;
  logic        man_ready = 1'b0;
  logic [63:0] man_res = '0;
  logic        dready_m;

  always @(posedge clk) begin
    if (div_cancel_o) dbusy <= 1'b0;
    else if (div_start_o) begin
      dbusy <= (dlat != 0);
      dcnt  <= dlat;
      dres  <= divm(unit_signed_o, unit_opa_o, unit_opb_o);
    end else if (dbusy) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) dbusy <= 1'b0;
    end
  end
  assign dready_m     = dbusy && (dcnt == 1);
  assign div_ready_i  = dready_m | man_ready;
  assign div_result_i = man_ready ? man_res : (dready_m ? dres : 64'hBAD1_BAD1_BAD1_BAD1);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  kind;
    logic        sgn;
    logic [31:0] a, b;
    int          lat;
    logic [31:0] hi, lo;
    int          stalls, ms, ds, cancels;
    logic        err;
  } vec_t;

  vec_t tbl [7];

  // Caller must be just after a falling edge; returns just after a falling edge in IDLE.
  task automatic run_vec(input vec_t v, input string nm);
    int st, ms, ds, cn;
    bit got;
    st = 0; ms = 0; ds = 0; cn = 0; got = 0;
    dlat = v.lat;
    op_kind_i = v.kind; signed_i = v.sgn; opa_i = v.a; opb_i = v.b; op_valid_i = 1'b1;
    for (int c = 0; c < 200; c++) begin
      #1;
      ms += int'(mul_start_o);
      ds += int'(div_start_o);
      cn += int'(div_cancel_o);
      if (result_valid_o) begin
        got = 1;
        break;
      end
      st += int'(stall_o);
      @(negedge clk);
    end
    chk({nm, " done"}, 64'(got), 64'd1);
    chk({nm, " stall cycles"}, 64'(st), 64'(v.stalls));
    chk({nm, " mul starts"}, 64'(ms), 64'(v.ms));
    chk({nm, " div starts"}, 64'(ds), 64'(v.ds));
    chk({nm, " cancels"}, 64'(cn), 64'(v.cancels));
    chk({nm, " hi"}, 64'(hi_o), 64'(v.hi));
    chk({nm, " lo"}, 64'(lo_o), 64'(v.lo));
    chk({nm, " err"}, 64'(err_o), 64'(v.err));
    chk({nm, " stall in done"}, 64'(stall_o), 64'd0);
    op_valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk({nm, " back to idle"}, 64'(result_valid_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    int ds;
    bit got;
    tbl[0] = '{OPK_MUL, 1'b1, 32'd7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 3, 1, 0, 0, 1'b0};
    tbl[1] = '{OPK_MUL, 1'b0, 32'hFFFF_FFFF, 32'd2, 0, 32'h0000_0001, 32'hFFFF_FFFE, 3, 1, 0, 0, 1'b0};
    tbl[2] = '{OPK_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd0, 32'd1, 3, 1, 0, 0, 1'b0};
    tbl[3] = '{OPK_DIV, 1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14, 35, 0, 1, 0, 1'b0};
    tbl[4] = '{OPK_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 7, 0, 1, 0, 1'b0};
`ifdef MULDIV_DIV0_FAST_EN
    tbl[5] = '{OPK_DIV, 1'b0, 32'd5, 32'd0, 3, 32'd5, 32'hFFFF_FFFF, 1, 0, 0, 0, 1'b0};
`else
    tbl[5] = '{OPK_DIV, 1'b0, 32'd5, 32'd0, 3, 32'd5, 32'hFFFF_FFFF, 5, 0, 1, 0, 1'b0};
`endif
    tbl[6] = '{OPK_DIV, 1'b0, 32'd9, 32'd3, 0, 32'd0, 32'd0, 41, 0, 1, 1, 1'b1};

    rst = 1'b0; op_valid_i = 1'b0; op_kind_i = OPK_NONE; signed_i = 1'b0;
    opa_i = '0; opb_i = '0; flush_i = 1'b0; pipe_stall_i = 1'b0;
    #12;
    chk("reset stall", 64'(stall_o), 64'd0);
    chk("reset valid", 64'(result_valid_o), 64'd0);
    chk("reset hi/lo", {hi_o, lo_o}, 64'd0);
    chk("reset err", 64'(err_o), 64'd0);
    chk("reset pulses", {61'd0, mul_start_o, div_start_o, div_cancel_o}, 64'd0);
    chk("reset unit", {unit_opa_o, unit_opb_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reserved and none kinds do nothing.
    op_valid_i = 1'b1; op_kind_i = 2'd3; #1;
    chk("kind3 stall", 64'(stall_o), 64'd0);
    @(negedge clk); op_kind_i = OPK_NONE; #1;
    chk("kind3 no start", {62'd0, mul_start_o, div_start_o}, 64'd0);
    chk("kind0 stall", 64'(stall_o), 64'd0);
    @(negedge clk); op_valid_i = 1'b0; #1;
    chk("kind0 no start", {61'd0, mul_start_o, div_start_o, result_valid_o}, 64'd0);

    // Flush wins over accept.
    op_valid_i = 1'b1; op_kind_i = OPK_MUL; flush_i = 1'b1; #1;
    chk("flush+acc stall", 64'(stall_o), 64'd0);
    @(negedge clk); flush_i = 1'b0; op_valid_i = 1'b0; #1;
    chk("flush+acc no start", {62'd0, mul_start_o, result_valid_o}, 64'd0);

    // Completed div held by a downstream stall must not be re-issued.
    @(negedge clk);
    dlat = 4; pipe_stall_i = 1'b1;
    op_valid_i = 1'b1; op_kind_i = OPK_DIV; signed_i = 1'b0; opa_i = 32'd100; opb_i = 32'd7;
    ds = 0; got = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      ds += int'(div_start_o);
      if (result_valid_o) begin got = 1; break; end
      @(negedge clk);
    end
    chk("hold done", 64'(got), 64'd1);
    chk("hold result", {hi_o, lo_o}, {32'd2, 32'd14});
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      ds += int'(div_start_o);
      chk($sformatf("hold valid %0d", k), 64'(result_valid_o), 64'd1);
    end
    pipe_stall_i = 1'b0; op_valid_i = 1'b0;
    @(negedge clk); #1;
    ds += int'(div_start_o);
    chk("hold released", 64'(result_valid_o), 64'd0);
    chk("hold single start", 64'(ds), 64'd1);

    // Flush in cycle 10 of a div, with a same-cycle and a late div_ready_i.
    dlat = 33;
    op_valid_i = 1'b1; op_kind_i = OPK_DIV; opa_i = 32'd50; opb_i = 32'd5;
    for (int c = 0; c < 10; c++) @(negedge clk);
    flush_i = 1'b1; op_valid_i = 1'b0; man_ready = 1'b1; man_res = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    flush_i = 1'b0; man_ready = 1'b0; #1;
    chk("flush cancel", 64'(div_cancel_o), 64'd1);
    chk("flush idle", {62'd0, result_valid_o, stall_o}, 64'd0);
    chk("flush hi/lo kept", {hi_o, lo_o}, {32'd2, 32'd14});
    @(negedge clk); #1;
    chk("flush cancel single", 64'(div_cancel_o), 64'd0);
    @(negedge clk); @(negedge clk);
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0; #1;
    chk("late ready ignored", {31'd0, result_valid_o, hi_o}, {32'd0, 32'd2});
    chk("late ready lo", 64'(lo_o), 64'd14);
    @(negedge clk);

    run_vec(tbl[6], "watchdog");

    // Asynchronous reset mid-operation.
    dlat = 33;
    op_valid_i = 1'b1; op_kind_i = OPK_DIV; opa_i = 32'd77; opb_i = 32'd3;
    for (int c = 0; c < 5; c++) @(negedge clk);
    #2;
    rst = 1'b0; op_valid_i = 1'b0; #1;
    chk("midreset stall/valid", {62'd0, stall_o, result_valid_o}, 64'd0);
    chk("midreset err", 64'(err_o), 64'd0);
    chk("midreset unit", {unit_opa_o, unit_opb_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
